// File: rtl/l2_mem_responder.sv
// l2_mem_responder: memory-side slave of the L2 memory interface.
// Consumes the arbiter's request / write-data / abort streams, serves reads,
// writes, bursts, LR/SC and swap AMOs from a single-port word RAM, and
// produces the read-return stream (no back-pressure).
module l2_mem_responder #(
    parameter int unsigned MEM_DEPTH_LOG2 = 12,
    parameter int unsigned ID_W           = 3,
    parameter logic [4:0]  AMO_LR         = 5'b00010,
    parameter logic [4:0]  AMO_SC         = 5'b00011
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            request_valid,
    output logic            request_pop,
    input  logic [29:0]     addr,
    input  logic [3:0]      be,
    input  logic            rnw,
    input  logic            is_amo,
    input  logic [4:0]      amo_type_or_burst_size,
    input  logic [ID_W-1:0] id,
    input  logic [31:0]     wr_data,
    input  logic            wr_data_valid,
    output logic            wr_data_read,
    output logic [31:0]     rd_data,
    output logic [ID_W-1:0] rd_id,
    output logic            rd_data_valid,
    input  logic            abort
);

    localparam int unsigned MEM_DEPTH = 32'd1 << MEM_DEPTH_LOG2;
    localparam int unsigned IDX_W     = MEM_DEPTH_LOG2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_BURST = 3'd1,
        WR_BURST = 3'd2,
        SC_WAIT  = 3'd3,
        SWAP_RD  = 3'd4,
        SWAP_WR  = 3'd5
    } state_e;

    state_e            state_q;
    logic [29:0]       addr_q;
    logic [3:0]        be_q;
    logic [4:0]        len_q;
    logic [4:0]        beat_q;
    logic [ID_W-1:0]   id_q;
    logic [1:0]        abort_cnt_q;
    logic [31:0]       rd_data_q;
    logic [ID_W-1:0]   rd_id_q;
    logic              rd_data_valid_q;
    logic [31:0]       mem_q [MEM_DEPTH];

    logic [29:0]       word_addr;
    logic [IDX_W-1:0]  ram_idx;
    logic              ram_re;
    logic              ram_we;
    logic              sc_consume;
    logic              last_beat;
    logic              unused_addr_hi;

    // Beat address is formed at full width, then wrapped to the RAM size.
    assign word_addr      = addr_q + 30'(beat_q);
    assign ram_idx        = word_addr[IDX_W-1:0];
    assign unused_addr_hi = ^word_addr[29:IDX_W];

    // Per-cycle strobes: RAM port usage, stream pops, abort-token consumption.
    always_comb begin
        last_beat    = (beat_q == len_q);
        ram_re       = (state_q == RD_BURST) || (state_q == SWAP_RD);
        sc_consume   = (state_q == SC_WAIT) && (abort_cnt_q != 2'd0);
        wr_data_read = 1'b0;
        case (state_q)
            WR_BURST, SWAP_WR: wr_data_read = wr_data_valid;
            SC_WAIT:           wr_data_read = wr_data_valid && (abort_cnt_q == 2'd0);
            default:           wr_data_read = 1'b0;
        endcase
        ram_we      = wr_data_read;
        request_pop = rst_n && (state_q == IDLE) && request_valid;
    end

    // Request sequencer: latch the head request and walk its beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            be_q    <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            id_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (request_pop) begin
                        addr_q <= addr;
                        be_q   <= be;
                        id_q   <= id;
                        beat_q <= '0;
                        len_q  <= is_amo ? 5'd0 : amo_type_or_burst_size;
                        if (!is_amo) begin
                            state_q <= rnw ? RD_BURST : WR_BURST;
                        end else if (amo_type_or_burst_size == AMO_LR) begin
                            state_q <= RD_BURST;
                        end else if (amo_type_or_burst_size == AMO_SC) begin
                            state_q <= SC_WAIT;
                        end else begin
                            state_q <= SWAP_RD;
                        end
                    end
                end
                RD_BURST: begin
                    if (last_beat) state_q <= IDLE;
                    else           beat_q  <= beat_q + 5'd1;
                end
                WR_BURST: begin
                    if (wr_data_valid) begin
                        if (last_beat) state_q <= IDLE;
                        else           beat_q  <= beat_q + 5'd1;
                    end
                end
                SC_WAIT: begin
                    if (sc_consume || wr_data_read) state_q <= IDLE;
                end
                SWAP_RD: state_q <= SWAP_WR;
                SWAP_WR: begin
                    if (wr_data_read) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Read return pipeline: one RAM read per issue, data one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_valid_q <= 1'b0;
            rd_data_q       <= '0;
            rd_id_q         <= '0;
        end else begin
            rd_data_valid_q <= ram_re;
            if (ram_re) begin
                rd_data_q <= mem_q[ram_idx];
                rd_id_q   <= id_q;
            end
        end
    end

    // RAM write port with per-byte enables; contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) mem_q[ram_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    // Outstanding failed-SC tokens; simultaneous +1/-1 cancel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abort_cnt_q <= '0;
        end else begin
            assert (!(abort && (abort_cnt_q == 2'd3)));
            case ({abort, sc_consume})
                2'b10:   if (abort_cnt_q != 2'd3) abort_cnt_q <= abort_cnt_q + 2'd1;
                2'b01:   abort_cnt_q <= abort_cnt_q - 2'd1;
                default: abort_cnt_q <= abort_cnt_q;
            endcase
        end
    end

    assign rd_data       = rd_data_q;
    assign rd_id         = rd_id_q;
    assign rd_data_valid = rd_data_valid_q;

endmodule

// File: tb/tb_l2_mem_responder.sv
// Bench for l2_mem_responder: request / write-data FIFOs modelled as queues,
// memory and return timing predicted from cycle arithmetic.
module tb_l2_mem_responder;

    localparam int unsigned ID_W   = 3;
    localparam int          DEPTH  = 4096;
    localparam logic [4:0]  AMO_LR = 5'b00010;
    localparam logic [4:0]  AMO_SC = 5'b00011;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            request_valid;
    logic            request_pop;
    logic [29:0]     addr;
    logic [3:0]      be;
    logic            rnw;
    logic            is_amo;
    logic [4:0]      amo_type_or_burst_size;
    logic [ID_W-1:0] id;
    logic [31:0]     wr_data;
    logic            wr_data_valid;
    logic            wr_data_read;
    logic [31:0]     rd_data;
    logic [ID_W-1:0] rd_id;
    logic            rd_data_valid;
    logic            abort;

    l2_mem_responder dut (
        .clk(clk), .rst_n(rst_n),
        .request_valid(request_valid), .request_pop(request_pop),
        .addr(addr), .be(be), .rnw(rnw), .is_amo(is_amo),
        .amo_type_or_burst_size(amo_type_or_burst_size), .id(id),
        .wr_data(wr_data), .wr_data_valid(wr_data_valid), .wr_data_read(wr_data_read),
        .rd_data(rd_data), .rd_id(rd_id), .rd_data_valid(rd_data_valid),
        .abort(abort)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [29:0]     a;
        logic [3:0]      b;
        logic            rd;
        logic            amo;
        logic [4:0]      f;
        logic [ID_W-1:0] i;
        bit              fail;
    } req_t;

    typedef struct {
        int              c;
        logic [31:0]     d;
        logic [ID_W-1:0] i;
    } beat_t;

    req_t            rq[$];
    logic [31:0]     wq[$];
    beat_t           got_q[$];
    int              pop_cyc_q[$];
    logic [31:0]     mdl_mem [DEPTH];
    logic [31:0]     exp_data [int];
    logic [ID_W-1:0] exp_id [int];

    int          cyc = 0;
    int          free_at = 0;
    int          data_ok_from = 0;
    int          pend_words = 0;
    int          pend_beat = 0;
    logic [29:0] pend_addr;
    logic [3:0]  pend_be;
    bit          gate_force_low = 0;
    bit          rand_gate = 0;
    int          wrd_seen = 0;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int widx(input logic [29:0] a, input int k);
        logic [29:0] s;
        s = a + 30'(k);
        return int'(s) & (DEPTH - 1);
    endfunction

    function automatic void push_req(input logic [29:0] a, input logic [3:0] b, input bit rd,
                                     input bit amo, input logic [4:0] f, input logic [ID_W-1:0] i,
                                     input bit fail);
        req_t r;
        r.a = a; r.b = b; r.rd = rd; r.amo = amo; r.f = f; r.i = i; r.fail = fail;
        rq.push_back(r);
    endfunction

    // Model reaction to a request being popped in the current cycle.
    task automatic accept(input req_t r);
        int len;
        pop_cyc_q.push_back(cyc);
        if (r.amo && r.f == AMO_SC) begin
            if (r.fail) begin
                abort   = 1'b1;
                free_at = cyc + 2;
            end else begin
                pend_words = 1; pend_beat = 0; pend_addr = r.a; pend_be = r.b;
                data_ok_from = cyc + 1;
            end
        end else if (r.amo && r.f != AMO_LR) begin
            exp_data[cyc + 2] = mdl_mem[widx(r.a, 0)];
            exp_id[cyc + 2]   = r.i;
            pend_words = 1; pend_beat = 0; pend_addr = r.a; pend_be = r.b;
            data_ok_from = cyc + 2;
        end else if (r.rd || r.amo) begin
            len = r.amo ? 1 : int'(r.f) + 1;
            for (int k = 0; k < len; k++) begin
                exp_data[cyc + 2 + k] = mdl_mem[widx(r.a, k)];
                exp_id[cyc + 2 + k]   = r.i;
            end
            free_at = cyc + 1 + len;
        end else begin
            pend_words = int'(r.f) + 1; pend_beat = 0; pend_addr = r.a; pend_be = r.b;
            data_ok_from = cyc + 1;
        end
    endtask

    // One clock: drive at negedge, sample and compare just before posedge.
    task automatic step();
        bit   e_pop, e_wrd, e_rdv, gate;
        int   w;
        @(negedge clk);
        abort = 1'b0;
        gate  = !gate_force_low && (!rand_gate || ($urandom_range(3) != 0));
        if (rq.size() > 0 && rst_n) begin
            request_valid = 1'b1;
            addr = rq[0].a; be = rq[0].b; rnw = rq[0].rd; is_amo = rq[0].amo;
            amo_type_or_burst_size = rq[0].f; id = rq[0].i;
        end else begin
            request_valid = 1'b0;
            addr = 30'($urandom); be = 4'($urandom); rnw = 1'($urandom);
            is_amo = 1'($urandom); amo_type_or_burst_size = 5'($urandom); id = 3'($urandom);
        end
        wr_data_valid = (wq.size() > 0) && gate;
        wr_data       = (wq.size() > 0) ? wq[0] : $urandom;
        #4;
        if (rst_n) begin
            e_pop = request_valid && (cyc >= free_at) && (pend_words == 0);
            e_wrd = (pend_words > 0) && (cyc >= data_ok_from) && wr_data_valid;
            e_rdv = exp_data.exists(cyc);
            chk("request_pop", 32'(request_pop), 32'(e_pop));
            chk("wr_data_read", 32'(wr_data_read), 32'(e_wrd));
            chk("rd_data_valid", 32'(rd_data_valid), 32'(e_rdv));
            if (rd_data_valid && e_rdv) begin
                chk("rd_data", rd_data, exp_data[cyc]);
                chk("rd_id", 32'(rd_id), 32'(exp_id[cyc]));
            end
            if (rd_data_valid) got_q.push_back('{c: cyc, d: rd_data, i: rd_id});
            if (e_rdv) begin
                exp_data.delete(cyc);
                exp_id.delete(cyc);
            end
            if (wr_data_read) wrd_seen++;
            if (wr_data_read && wr_data_valid && pend_words > 0) begin
                w = widx(pend_addr, pend_beat);
                for (int b = 0; b < 4; b++)
                    if (pend_be[b]) mdl_mem[w][8*b +: 8] = wq[0][8*b +: 8];
                void'(wq.pop_front());
                pend_beat++;
                pend_words--;
                if (pend_words == 0) free_at = cyc + 1;
            end
            if (request_pop && request_valid) accept(rq.pop_front());
        end
        cyc++;
    endtask

    task automatic clear_model();
        rq.delete(); wq.delete(); exp_data.delete(); exp_id.delete();
        pend_words = 0; free_at = cyc;
    endtask

    task automatic run_idle(input int max_cyc);
        int n;
        n = 0;
        while (!(rq.size() == 0 && wq.size() == 0 && pend_words == 0 &&
                 exp_data.num() == 0 && cyc >= free_at)) begin
            if (n >= max_cyc) begin
                checks++; errors++;
                $display("FAIL timeout: idle not reached within %0d cycles (cycle %0d)", max_cyc, cyc);
                clear_model();
                return;
            end
            step();
            n++;
        end
    endtask

    task automatic wr1(input logic [29:0] a, input logic [3:0] b, input logic [31:0] d);
        push_req(a, b, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0);
        wq.push_back(d);
    endtask

    task automatic rd_single(input logic [29:0] a, input logic [ID_W-1:0] i, input logic [31:0] exp, input string nm);
        got_q.delete(); pop_cyc_q.delete();
        push_req(a, 4'hF, 1'b1, 1'b0, 5'd0, i, 1'b0);
        run_idle(100);
        chk({nm, "_beats"}, 32'(got_q.size()), 32'd1);
        if (got_q.size() >= 1) chk({nm, "_data"}, got_q[0].d, exp);
    endtask

    task automatic rd_burst8(input logic [29:0] a, input logic [31:0] base, input string nm);
        got_q.delete(); pop_cyc_q.delete();
        push_req(a, 4'hF, 1'b1, 1'b0, 5'd7, 3'd2, 1'b0);
        run_idle(100);
        chk({nm, "_beats"}, 32'(got_q.size()), 32'd8);
        for (int k = 0; k < got_q.size() && k < 8; k++) begin
            chk({nm, "_data"}, got_q[k].d, base + 32'(k));
            chk({nm, "_cycle"}, 32'(got_q[k].c), 32'(pop_cyc_q[0] + 2 + k));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [4:0]  t;
        logic [4:0]  f;
        int          kind;
        bit          fl;
        rst_n = 1'b0; request_valid = 1'b0; addr = '0; be = '0; rnw = 1'b0; is_amo = 1'b0;
        amo_type_or_burst_size = '0; id = '0; wr_data = '0; wr_data_valid = 1'b0; abort = 1'b0;
        #1;
        chk("reset_rd_valid", 32'(rd_data_valid), 32'd0);
        chk("reset_pop", 32'(request_pop), 32'd0);
        chk("reset_wr_read", 32'(wr_data_read), 32'd0);
        chk("reset_rd_data", rd_data, 32'd0);
        chk("reset_rd_id", 32'(rd_id), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Fill all of RAM through 32-beat write bursts.
        for (int i = 0; i < DEPTH / 32; i++) begin
            push_req(30'(i * 32), 4'hF, 1'b0, 1'b0, 5'd31, 3'd0, 1'b0);
            for (int k = 0; k < 32; k++) wq.push_back($urandom);
        end
        run_idle(6000);

        // Single read.
        wr1(30'h10, 4'hF, 32'hDEADBEEF);
        run_idle(100);
        got_q.delete(); pop_cyc_q.delete();
        push_req(30'h10, 4'hF, 1'b1, 1'b0, 5'd0, 3'd5, 1'b0);
        run_idle(100);
        chk("single_beats", 32'(got_q.size()), 32'd1);
        if (got_q.size() >= 1) begin
            chk("single_data", got_q[0].d, 32'hDEADBEEF);
            chk("single_id", 32'(got_q[0].i), 32'd5);
            chk("single_latency", 32'(got_q[0].c - pop_cyc_q[0]), 32'd2);
        end

        // Burst read, then a burst that wraps past the top of RAM.
        push_req(30'h20, 4'hF, 1'b0, 1'b0, 5'd7, 3'd0, 1'b0);
        for (int k = 0; k < 8; k++) wq.push_back(32'(k));
        run_idle(100);
        rd_burst8(30'h20, 32'd0, "burst");
        push_req(30'hFFC, 4'hF, 1'b0, 1'b0, 5'd7, 3'd0, 1'b0);
        for (int k = 0; k < 8; k++) wq.push_back(32'h100 + 32'(k));
        run_idle(100);
        rd_burst8(30'hFFC, 32'h100, "wrap");
        rd_single(30'h000, 3'd1, 32'h104, "wrap_low");

        // Byte-enable write with a stalled write-data stream.
        wr1(30'h40, 4'hF, 32'h11223344);
        run_idle(100);
        gate_force_low = 1;
        wr1(30'h40, 4'b0101, 32'hAABBCCDD);
        wrd_seen = 0;
        repeat (4) step();
        chk("stall_no_read", 32'(wrd_seen), 32'd0);
        gate_force_low = 0;
        run_idle(100);
        rd_single(30'h40, 3'd3, 32'h11BB33DD, "be_write");

        // SC ordering: failed SC consumes its abort token, next SC takes the data.
        wr1(30'h50, 4'hF, 32'h0000A5A5);
        wr1(30'h54, 4'hF, 32'h0);
        run_idle(100);
        got_q.delete();
        push_req(30'h50, 4'hF, 1'b0, 1'b1, AMO_SC, 3'd1, 1'b1);
        push_req(30'h54, 4'hF, 1'b0, 1'b1, AMO_SC, 3'd2, 1'b0);
        wq.push_back(32'h5);
        run_idle(100);
        chk("sc_no_return", 32'(got_q.size()), 32'd0);
        rd_single(30'h50, 3'd0, 32'h0000A5A5, "sc_a");
        rd_single(30'h54, 3'd0, 32'h5, "sc_b");
        rd_single(30'h54, 3'd4, 32'h5, "sc_cnt_clear");

        // Swap returns the old word, then stores the new one.
        wr1(30'h60, 4'hF, 32'h7);
        run_idle(100);
        got_q.delete();
        push_req(30'h60, 4'hF, 1'b0, 1'b1, 5'b00001, 3'd6, 1'b0);
        wq.push_back(32'h9);
        run_idle(100);
        chk("swap_beats", 32'(got_q.size()), 32'd1);
        if (got_q.size() >= 1) begin
            chk("swap_old", got_q[0].d, 32'h7);
            chk("swap_id", 32'(got_q[0].i), 32'd6);
        end
        rd_single(30'h60, 3'd0, 32'h9, "swap_new");

        // Random mix of all request kinds with a gappy write-data stream.
        rand_gate = 1;
        for (int n = 0; n < 250; n++) begin
            kind = $urandom_range(9);
            f = ($urandom_range(7) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(7));
            if (kind <= 2) begin
                push_req(30'($urandom), 4'hF, 1'b1, 1'b0, f, 3'($urandom), 1'b0);
            end else if (kind <= 5) begin
                push_req(30'($urandom), 4'($urandom), 1'b0, 1'b0, f, 3'($urandom), 1'b0);
                for (int k = 0; k <= int'(f); k++) wq.push_back($urandom);
            end else if (kind == 6) begin
                push_req(30'($urandom), 4'hF, 1'($urandom), 1'b1, AMO_LR, 3'($urandom), 1'b0);
            end else if (kind == 7) begin
                fl = 1'($urandom);
                push_req(30'($urandom), 4'($urandom), 1'b0, 1'b1, AMO_SC, 3'($urandom), fl);
                if (!fl) wq.push_back($urandom);
            end else begin
                t = 5'($urandom);
                if (t == AMO_LR || t == AMO_SC) t = 5'd1;
                push_req(30'($urandom), 4'($urandom), 1'($urandom), 1'b1, t, 3'($urandom), 1'b0);
                wq.push_back($urandom);
            end
        end
        run_idle(30000);
        rand_gate = 0;

        // Reset in the middle of a read burst.
        got_q.delete();
        push_req(30'h20, 4'hF, 1'b1, 1'b0, 5'd7, 3'd3, 1'b0);
        for (int n = 0; n < 60 && got_q.size() < 3; n++) step();
        chk("midburst_beats_before_reset", 32'(got_q.size()), 32'd3);
        @(negedge clk);
        rst_n = 1'b0;
        request_valid = 1'b0; wr_data_valid = 1'b0; abort = 1'b0;
        #1;
        chk("midrst_rd_valid", 32'(rd_data_valid), 32'd0);
        chk("midrst_pop", 32'(request_pop), 32'd0);
        chk("midrst_wr_read", 32'(wr_data_read), 32'd0);
        clear_model();
        repeat (3) begin
            @(negedge clk);
            chk("inrst_rd_valid", 32'(rd_data_valid), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        free_at = cyc;
        got_q.delete(); pop_cyc_q.delete();
        push_req(30'h10, 4'hF, 1'b1, 1'b0, 5'd0, 3'd1, 1'b0);
        run_idle(100);
        chk("post_reset_beats", 32'(got_q.size()), 32'd1);
        if (got_q.size() >= 1) begin
            chk("post_reset_data", got_q[0].d, 32'hDEADBEEF);
            chk("post_reset_latency", 32'(got_q[0].c - pop_cyc_q[0]), 32'd2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
